// File: rtl/cv32e41s_irq_prio_ctrl.sv
// cv32e41s_irq_prio_ctrl: prioritised interrupt controller with per-line priority/enable/trigger
// mode, edge-pending latches, threshold nesting stack and ack/return handshake.
// Optional feature macro: CV32E41S_IRQ_WU_EN (combinational wake-up from raw irq_i).
module cv32e41s_irq_prio_ctrl #(
    parameter int unsigned NUM_IRQ    = 32,
    parameter int unsigned PRIO_W     = 3,
    parameter int unsigned NEST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IRQ-1:0]         irq_i,
    input  logic                       cfg_we_i,
    input  logic [$clog2(NUM_IRQ)-1:0] cfg_id_i,
    input  logic [PRIO_W-1:0]          cfg_prio_i,
    input  logic                       cfg_ie_i,
    input  logic                       cfg_edge_i,
    input  logic                       mstatus_mie_i,
    output logic                       irq_req_o,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id_o,
    output logic [PRIO_W-1:0]          irq_prio_o,
    input  logic                       irq_ack_i,
    input  logic                       irq_ret_i,
    output logic [NUM_IRQ-1:0]         ip_o,
    output logic [PRIO_W-1:0]          thresh_o,
    output logic                       irq_wu_o
);

    localparam int unsigned ID_W    = $clog2(NUM_IRQ);
    localparam int unsigned DEPTH_W = $clog2(NEST_DEPTH + 1);
    localparam int unsigned IDX_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irq_q_d;
    logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
    logic [NUM_IRQ-1:0] ie_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] lat_q;
    logic [PRIO_W-1:0]  stack_q [NEST_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [PRIO_W-1:0]  thresh_q;

    logic [NUM_IRQ-1:0] ip_c;
    logic [NUM_IRQ-1:0] cand_c;
    logic [NUM_IRQ-1:0] rise_c;
    logic [NUM_IRQ-1:0] mode_sw_c;
    logic [NUM_IRQ-1:0] ack_clr_c;
    logic [NUM_IRQ-1:0] lat_d_c;
    logic               win_found_c;
    logic [ID_W-1:0]    win_id_c;
    logic [PRIO_W-1:0]  win_prio_c;
    logic               ack_acc_c;
    logic               cfg_valid_c;
    logic               stack_full_c;
    logic [IDX_W-1:0]   push_idx_c;
    logic [IDX_W-1:0]   pop_idx_c;

    assign ack_acc_c    = irq_ack_i & irq_req_o;
    assign cfg_valid_c  = cfg_we_i && ({1'b0, cfg_id_i} < (ID_W + 1)'(NUM_IRQ));
    assign stack_full_c = (depth_q == DEPTH_W'(NEST_DEPTH));
    assign push_idx_c   = IDX_W'(depth_q);
    assign pop_idx_c    = IDX_W'(depth_q - DEPTH_W'(1));
    assign rise_c       = irq_q & ~irq_q_d;
    assign ip_c         = (irq_q & ~edge_q) | (lat_q & edge_q);

    // Per-line candidate mask, latch set/clear terms
    always_comb begin
        cand_c    = '0;
        mode_sw_c = '0;
        ack_clr_c = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            cand_c[i]    = ip_c[i] & ie_q[i] & (prio_q[i] > thresh_q);
            mode_sw_c[i] = cfg_valid_c && (cfg_id_i == ID_W'(i)) && (cfg_edge_i != edge_q[i]);
            ack_clr_c[i] = ack_acc_c && (irq_id_o == ID_W'(i));
        end
        // A rise wins over an ack clear; a mode switch wins over both
        lat_d_c = edge_q & ~mode_sw_c & ((lat_q & ~ack_clr_c) | rise_c);
    end

    // Winner: highest priority, ties resolved towards the highest id
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = '0;
        win_prio_c  = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (cand_c[i] && (!win_found_c || (prio_q[i] >= win_prio_c))) begin
                win_found_c = 1'b1;
                win_id_c    = ID_W'(i);
                win_prio_c  = prio_q[i];
            end
        end
    end

    // Input sampling, line configuration and pending latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            irq_q_d <= '0;
            ie_q    <= '0;
            edge_q  <= '0;
            lat_q   <= '0;
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            irq_q   <= irq_i;
            irq_q_d <= irq_q;
            lat_q   <= lat_d_c;
            if (cfg_valid_c) begin
                prio_q[cfg_id_i] <= cfg_prio_i;
                ie_q[cfg_id_i]   <= cfg_ie_i;
                edge_q[cfg_id_i] <= cfg_edge_i;
            end
        end
    end

    // Threshold nesting stack: ack pushes, ret pops, both together only swaps the threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q  <= '0;
            thresh_q <= '0;
            for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (irq_ret_i && ack_acc_c) begin
            thresh_q <= irq_prio_o;
        end else if (irq_ret_i) begin
            if (depth_q != '0) begin
                thresh_q <= stack_q[pop_idx_c];
                depth_q  <= depth_q - DEPTH_W'(1);
            end else begin
                thresh_q <= '0;
            end
        end else if (ack_acc_c && !stack_full_c) begin
            stack_q[push_idx_c] <= thresh_q;
            depth_q             <= depth_q + DEPTH_W'(1);
            thresh_q            <= irq_prio_o;
        end
    end

    // Registered request towards the core controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req_o  <= 1'b0;
            irq_id_o   <= '0;
            irq_prio_o <= '0;
        end else begin
            irq_req_o  <= win_found_c & mstatus_mie_i & ~stack_full_c & ~ack_acc_c;
            irq_id_o   <= win_id_c;
            irq_prio_o <= win_prio_c;
        end
    end

    assign ip_o     = ip_c;
    assign thresh_o = thresh_q;

`ifdef CV32E41S_IRQ_WU_EN
    logic [NUM_IRQ-1:0] prio_nz_c;

    // Lines able to wake the core: enabled with a non-zero priority
    always_comb begin
        prio_nz_c = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            prio_nz_c[i] = (prio_q[i] != '0);
        end
    end

    assign irq_wu_o = |(irq_i & ie_q & prio_nz_c);
`else
    assign irq_wu_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e41s_irq_prio_ctrl.sv
// Self-checking bench for cv32e41s_irq_prio_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of lines, pending state and threshold stack.
module tb_cv32e41s_irq_prio_ctrl;

    localparam int unsigned N    = 12;
    localparam int unsigned PW   = 3;
    localparam int unsigned ND   = 2;
    localparam int unsigned IW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_i;
    logic          cfg_we_i;
    logic [IW-1:0] cfg_id_i;
    logic [PW-1:0] cfg_prio_i;
    logic          cfg_ie_i;
    logic          cfg_edge_i;
    logic          mstatus_mie_i;
    logic          irq_req_o;
    logic [IW-1:0] irq_id_o;
    logic [PW-1:0] irq_prio_o;
    logic          irq_ack_i;
    logic          irq_ret_i;
    logic [N-1:0]  ip_o;
    logic [PW-1:0] thresh_o;
    logic          irq_wu_o;

    cv32e41s_irq_prio_ctrl #(.NUM_IRQ(N), .PRIO_W(PW), .NEST_DEPTH(ND)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq_i),
        .cfg_we_i(cfg_we_i), .cfg_id_i(cfg_id_i), .cfg_prio_i(cfg_prio_i),
        .cfg_ie_i(cfg_ie_i), .cfg_edge_i(cfg_edge_i), .mstatus_mie_i(mstatus_mie_i),
        .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .irq_prio_o(irq_prio_o),
        .irq_ack_i(irq_ack_i), .irq_ret_i(irq_ret_i), .ip_o(ip_o),
        .thresh_o(thresh_o), .irq_wu_o(irq_wu_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_prio [N];
    bit m_ie   [N];
    bit m_edge [N];
    bit m_lat  [N];
    bit m_q    [N];
    bit m_qd   [N];
    int m_thresh;
    int m_stack[$];
    bit m_req;
    int m_id;
    int m_prio_o;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prio[i] = 0; m_ie[i] = 0; m_edge[i] = 0;
            m_lat[i] = 0; m_q[i] = 0; m_qd[i] = 0;
        end
        m_thresh = 0;
        m_stack.delete();
        m_req = 0; m_id = 0; m_prio_o = 0;
    endtask

    function automatic int unsigned model_ip();
        int unsigned v = 0;
        for (int i = 0; i < N; i++)
            if (m_edge[i] ? m_lat[i] : m_q[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int unsigned model_wu();
`ifdef CV32E41S_IRQ_WU_EN
        for (int i = 0; i < N; i++)
            if (irq_i[i] && m_ie[i] && m_prio[i] != 0) return 1;
`endif
        return 0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_update();
        bit acc;
        int bid, bp;
        bit found, nreq;
        bit new_lat [N];
        int pend;
        acc = irq_ack_i && m_req;
        // Scan from the top id down, only a strictly higher priority replaces the pick
        found = 0; bid = 0; bp = m_thresh;
        for (int i = N - 1; i >= 0; i--) begin
            pend = m_edge[i] ? m_lat[i] : m_q[i];
            if (pend != 0 && m_ie[i] && m_prio[i] > bp) begin
                found = 1; bid = i; bp = m_prio[i];
            end
        end
        if (!found) bp = 0;
        nreq = found && mstatus_mie_i && (m_stack.size() < ND) && !acc;
        for (int i = 0; i < N; i++) begin
            if (!m_edge[i]) new_lat[i] = 0;
            else if (cfg_we_i && cfg_id_i < N && int'(cfg_id_i) == i && cfg_edge_i != m_edge[i]) new_lat[i] = 0;
            else if (m_q[i] && !m_qd[i]) new_lat[i] = 1;
            else if (acc && m_id == i) new_lat[i] = 0;
            else new_lat[i] = m_lat[i];
        end
        if (irq_ret_i && acc) m_thresh = m_prio_o;
        else if (irq_ret_i) m_thresh = (m_stack.size() > 0) ? m_stack.pop_back() : 0;
        else if (acc) begin
            m_stack.push_back(m_thresh);
            m_thresh = m_prio_o;
        end
        for (int i = 0; i < N; i++) m_lat[i] = new_lat[i];
        if (cfg_we_i && cfg_id_i < N) begin
            m_prio[cfg_id_i] = int'(cfg_prio_i);
            m_ie[cfg_id_i]   = cfg_ie_i;
            m_edge[cfg_id_i] = cfg_edge_i;
        end
        for (int i = 0; i < N; i++) begin
            m_qd[i] = m_q[i];
            m_q[i]  = irq_i[i];
        end
        m_req = nreq; m_id = bid; m_prio_o = bp;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".req"}, irq_req_o, m_req);
        check({tag, ".thresh"}, thresh_o, m_thresh);
        check({tag, ".ip"}, ip_o, model_ip());
        check({tag, ".wu"}, irq_wu_o, model_wu());
        if (m_req) begin
            check({tag, ".id"}, irq_id_o, m_id);
            check({tag, ".prio"}, irq_prio_o, m_prio_o);
        end
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
        cfg_we_i  = 0;
        irq_ack_i = 0;
        irq_ret_i = 0;
    endtask

    task automatic cfg_line(input int id, input int prio, input bit ie, input bit edg);
        cfg_we_i = 1; cfg_id_i = IW'(id); cfg_prio_i = PW'(prio);
        cfg_ie_i = ie; cfg_edge_i = edg;
        step("cfg");
    endtask

    initial begin
        rst_n = 0; irq_i = '0; cfg_we_i = 0; cfg_id_i = '0; cfg_prio_i = '0;
        cfg_ie_i = 0; cfg_edge_i = 0; mstatus_mie_i = 1; irq_ack_i = 0; irq_ret_i = 0;
        model_reset();
        #1;
        compare_all("reset");
        check("reset.id", irq_id_o, 0);
        check("reset.prio", irq_prio_o, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Level line 11: request two edges after irq_i is sampled
        cfg_line(11, 3, 1, 0);
        irq_i[11] = 1;
        step("t1a");
        check("t1.req_early", irq_req_o, 0);
        step("t1b");
        check("t1.req", irq_req_o, 1);
        check("t1.id", irq_id_o, 11);
        check("t1.prio", irq_prio_o, 3);

        // Tie between 5 and 9 resolves to 9; raising 5 flips the winner
        cfg_line(11, 3, 0, 0);
        irq_i = '0;
        cfg_line(5, 2, 1, 0);
        cfg_line(9, 2, 1, 0);
        irq_i[5] = 1; irq_i[9] = 1;
        step("t2a");
        step("t2b");
        check("t2.tie_id", irq_id_o, 9);
        cfg_line(5, 4, 1, 0);
        check("t2.cfg_delay_id", irq_id_o, 9);
        step("t2c");
        check("t2.raised_id", irq_id_o, 5);
        check("t2.raised_prio", irq_prio_o, 4);

        // Edge line 3: one-cycle pulse stays pending until acknowledged
        irq_i = '0;
        cfg_line(5, 4, 0, 0);
        cfg_line(9, 2, 0, 0);
        cfg_line(3, 1, 1, 1);
        irq_i[3] = 1;
        step("t3a");
        irq_i[3] = 0;
        step("t3b");
        step("t3c");
        step("t3d");
        check("t3.ip_held", ip_o[3], 1);
        check("t3.req", irq_req_o, 1);
        check("t3.id", irq_id_o, 3);
        irq_ack_i = 1;
        step("t3e");
        check("t3.ip_cleared", ip_o[3], 0);
        check("t3.req_after_ack", irq_req_o, 0);
        check("t3.thresh", thresh_o, 1);
        irq_ret_i = 1;
        step("t3f");
        check("t3.thresh_ret", thresh_o, 0);
        irq_ret_i = 1;
        step("t3g");
        check("t3.ret_empty", thresh_o, 0);

        // Out-of-range config write is ignored
        cfg_line(13, 7, 1, 0);
        cfg_line(3, 0, 0, 0);

        // Enter a handler at threshold 4, then reset asynchronously mid-cycle
        cfg_line(7, 4, 1, 0);
        irq_i[7] = 1;
        step("t6a");
        step("t6b");
        irq_ack_i = 1;
        step("t6c");
        check("t6.thresh", thresh_o, 4);
`ifdef CV32E41S_IRQ_WU_EN
        irq_i[7] = 0; #1;
        check("t6.wu_low", irq_wu_o, 0);
        irq_i[7] = 1; #1;
        check("t6.wu_high", irq_wu_o, 1);
`endif
        #2 rst_n = 0;
        #1;
        model_reset();
        irq_i = '0;
        #1;
        compare_all("t6.rst");
        check("t6.rst_thresh", thresh_o, 0);
        check("t6.rst_id", irq_id_o, 0);
        check("t6.rst_prio", irq_prio_o, 0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            irq_i ^= N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) begin
                cfg_we_i = 1; cfg_id_i = IW'($urandom_range(0, 15));
                cfg_prio_i = PW'($urandom); cfg_ie_i = ($urandom_range(0, 3) != 0);
                cfg_edge_i = $urandom_range(0, 1) != 0;
            end
            mstatus_mie_i = ($urandom_range(0, 9) != 0);
            irq_ack_i     = ($urandom_range(0, 1) != 0);
            irq_ret_i     = ($urandom_range(0, 11) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
